// File: rtl/stream_fifo_if.sv
// rtl/stream_fifo_if.sv - write/read stream handshake bundle for stream_fifo
interface stream_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;

    modport master (
        output wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - FWFT stream FIFO with full-policy, thresholds, flush and sticky errors
module stream_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DATA_ENTRIES = 256,
    parameter int OVERWRITE    = 0,
    parameter int AF_LEVEL     = DATA_ENTRIES - 1,
    parameter int AE_LEVEL     = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    stream_fifo_if.slave                    s,
    input  logic                            flush,
    input  logic                            err_clear,
    output logic [$clog2(DATA_ENTRIES):0]   count,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic                            overflow,
    output logic                            underflow
);
    localparam int PTR_W = $clog2(DATA_ENTRIES);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem [DATA_ENTRIES];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic push;
    logic pop;
    logic rd_adv;
    logic ovf_event;
    logic unf_event;

    assign full         = (count == CNT_W'(DATA_ENTRIES));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count <= CNT_W'(AE_LEVEL));

    assign s.wr_ready = (OVERWRITE != 0) ? 1'b1 : ~full;
    assign s.rd_valid = ~empty;
    assign s.rd_data  = mem[rd_ptr];

    assign push = s.wr_valid & s.wr_ready;
    assign pop  = s.rd_valid & s.rd_ready;

    // A push into a full FIFO (only possible when overwriting) evicts the oldest entry.
    assign rd_adv = pop | (push & full);

    assign ovf_event = (OVERWRITE != 0) ? (push & full & ~pop) : (s.wr_valid & full);
    assign unf_event = s.rd_ready & empty;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= s.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop && !full) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Set wins over err_clear so an error in the clearing cycle is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_event | (overflow  & ~err_clear);
            underflow <= unf_event | (underflow & ~err_clear);
        end
    end
endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised first-word-fall-through FIFO for the SPI datapath and any other byte/word stream that needs buffering between producer and consumer logic on one clock. It generalises the team's basic FIFO with valid/ready handshakes, a selectable full-policy (drop-new or overwrite-oldest), programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 8, width of each entry
- DATA_ENTRIES, 256, depth; must be a power of 2, at least 2
- OVERWRITE, 0, full-policy: 0 = drop new data, 1 = discard oldest entry to admit new data
- AF_LEVEL, DATA_ENTRIES-1, almost_full asserts when count >= AF_LEVEL (1..DATA_ENTRIES)
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DATA_ENTRIES-1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- wr_data  in  DATA_WIDTH  write data
- wr_valid  in  1  producer offers wr_data
- wr_ready  out  1  FIFO accepts; OVERWRITE=0: ~full; OVERWRITE=1: constant 1
- rd_data  out  DATA_WIDTH  oldest entry, combinational from memory (FWFT)
- rd_valid  out  1  ~empty
- rd_ready  in  1  consumer pops when rd_valid & rd_ready
- flush  in  1  synchronous clear of contents
- err_clear  in  1  clears sticky error flags
- count  out  $clog2(DATA_ENTRIES)+1  current occupancy, 0..DATA_ENTRIES
- full, empty, almost_full, almost_empty  out  1 each  occupancy flags
- overflow, underflow  out  1 each  sticky error flags

## Operation
- Storage: DATA_ENTRIES x DATA_WIDTH array, not reset. Write and read pointers are $clog2(DATA_ENTRIES) bits and wrap naturally from DATA_ENTRIES-1 to 0.
- push = wr_valid & wr_ready; pop = rd_valid & rd_ready.
- push only: write at wr_ptr, wr_ptr+1, count+1.
- pop only: rd_ptr+1, count-1.
- push & pop together: both pointers advance, count unchanged. This is legal at any occupancy, including full with OVERWRITE=1.
- OVERWRITE=1, full, push without pop: write at wr_ptr; wr_ptr+1 and rd_ptr+1 so the oldest entry is discarded; count stays DATA_ENTRIES; overflow set.
- OVERWRITE=0, wr_valid while full: data dropped, no state change except overflow set.
- rd_ready while empty: no pop, underflow set.
- flush (highest priority): next edge clears wr_ptr, rd_ptr and count to 0; push/pop in the same cycle are ignored; overflow/underflow are unaffected.
- err_clear clears overflow and underflow. If a new error condition occurs in the same cycle, set wins.
- Flags are combinational decodes of the count register:
  - full = (count == DATA_ENTRIES)
  - empty = (count == 0)
  - almost_full = (count >= AF_LEVEL)
  - almost_empty = (count <= AE_LEVEL)
- Count is never allowed to go outside 0..DATA_ENTRIES.

## Timing
- Reset values: count 0, empty 1, rd_valid 0, full 0, wr_ready 1, almost_full 0, almost_empty 1, overflow 0, underflow 0. Pointers are 0. rd_data is don't-care while rd_valid=0.
- Reset asserted mid-operation takes effect immediately and asynchronously. Memory contents are kept but unreachable.
- Write-to-read latency: data pushed at edge k appears on rd_data with rd_valid=1 after edge k, i.e. poppable in cycle k+1.
- Pop takes effect at the edge. rd_data shows the next entry combinationally after that edge.
- All flags and count update one edge after the causing push/pop/flush. Sticky flags assert at the edge following the error cycle.

## Test plan
(DATA_WIDTH=8, DATA_ENTRIES=4, AF_LEVEL=3, AE_LEVEL=1)
- Reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles. Required: count 1,2,3,4; almost_full at count 3; full=1 and wr_ready=0 at count 4 (OVERWRITE=0). Pop 4 times: rd_data 0x11..0x44 in order, then empty=1, almost_empty=1.
- OVERWRITE=0, full, push 0x55. Required: overflow=1, contents unchanged. Pop all: 0x11,0x22,0x33,0x44. Assert err_clear: overflow=0.
- OVERWRITE=1, full with 0x11..0x44, push 0x55 then 0x66. Required: count stays 4, overflow=1, pops return 0x33,0x44,0x55,0x66.
- Pointer wrap: run 10 cycles of simultaneous push/pop with count held at 2, data 0x00..0x09. Required: count constant 2, popped data is the pushed sequence delayed by 2, no flag toggles.
- Empty FIFO with rd_ready=1: underflow=1, count 0. Push 0xA5 with err_clear and rd_ready asserted in the same cycle while empty: underflow stays 1 (set wins); 0xA5 is readable next cycle.
- Count 3, flush asserted together with push 0x77 and pop. Required: next cycle count 0, empty=1, rd_valid=0, 0x77 is not stored. Assert reset mid-burst: all outputs return to reset values immediately.
